// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and state encoding for the data-memory arbiter.
package dmem_arbiter_pkg;

   localparam int MEM_WORDS = 16384;
   localparam int MEM_AW    = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_RESP  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin picker with a master-1 lock override.
module rr_arbiter2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   input  logic       i_lock,
   output logic       o_valid,
   output logic       o_idx
);

   // Lock grants master 1 only; otherwise a tie goes to whoever was not served last.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = 1'b0;
      if (i_lock) begin
         o_valid = i_req[1];
         o_idx   = 1'b1;
      end else begin
         case (i_req)
            2'b01:   begin o_valid = 1'b1; o_idx = 1'b0;    end
            2'b10:   begin o_valid = 1'b1; o_idx = 1'b1;    end
            2'b11:   begin o_valid = 1'b1; o_idx = ~i_last; end
            default: begin o_valid = 1'b0; o_idx = 1'b0;    end
         endcase
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port synchronous data memory.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ARB_IDLE  | no access in flight, arbitrating incoming requests
//  ARB_ISSUE | memory enabled for the owner (suppressed if out of range)
//  ARB_RESP  | owner gets rvalid/err; a new grant may be taken this cycle
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [AW-1:0]     m0_addr,
   input  logic [DW-1:0]     m0_wdata,
   output logic [DW-1:0]     m0_rdata,
   output logic              m0_rvalid,
   output logic              m0_err,
   output logic              cpu_stall,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [AW-1:0]     m1_addr,
   input  logic [DW-1:0]     m1_wdata,
   output logic [DW-1:0]     m1_rdata,
   output logic              m1_rvalid,
   output logic              m1_err,
   input  logic              m1_lock,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata
);

   localparam logic [AW-3:0] LP_WORDS = (AW-2)'(MEM_WORDS);

   arb_state_t      r_state;
   arb_state_t      w_state_nxt;
   logic            r_owner;
   logic            r_rr_last;
   logic            r_we;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_wdata;

   logic            w_arb_last;
   logic            w_lock_held;
   logic            w_gnt_valid;
   logic            w_gnt_idx;
   logic            w_take;
   logic            w_in_range;

   // While responding, the current owner counts as the last-served master.
   assign w_arb_last  = (r_state == ARB_RESP) ? r_owner : r_rr_last;
   assign w_lock_held = r_owner & m1_lock;
   assign w_take      = ((r_state == ARB_IDLE) || (r_state == ARB_RESP)) & w_gnt_valid;
   assign w_in_range  = (r_addr[AW-1:2] < LP_WORDS);

   rr_arbiter2 u_rr (
      .i_req   ({m1_req, m0_req}),
      .i_last  (w_arb_last),
      .i_lock  (w_lock_held),
      .o_valid (w_gnt_valid),
      .o_idx   (w_gnt_idx)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ARB_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ARB_IDLE:  w_state_nxt = w_take ? ARB_ISSUE : ARB_IDLE;
         ARB_ISSUE: w_state_nxt = ARB_RESP;
         ARB_RESP:  w_state_nxt = w_take ? ARB_ISSUE : ARB_IDLE;
         default:   w_state_nxt = ARB_IDLE;
      endcase
   end

   // Capture the winner's request at grant; remember who was served last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner   <= 1'b0;
         r_rr_last <= 1'b1;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
      end else begin
         if (w_take) begin
            r_owner <= w_gnt_idx;
            r_we    <= w_gnt_idx ? m1_we    : m0_we;
            r_addr  <= w_gnt_idx ? m1_addr  : m0_addr;
            r_wdata <= w_gnt_idx ? m1_wdata : m0_wdata;
         end
         if (r_state == ARB_RESP) r_rr_last <= r_owner;
      end
   end

   // Memory strobes in ISSUE, response routing in RESP.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = r_addr[MEM_AW+1:2];
      mem_wdata = r_wdata;
      m0_rvalid = 1'b0;
      m0_err    = 1'b0;
      m0_rdata  = '0;
      m1_rvalid = 1'b0;
      m1_err    = 1'b0;
      m1_rdata  = '0;
      if (r_state == ARB_ISSUE) begin
         mem_en = w_in_range;
         mem_we = w_in_range & r_we;
      end
      if (r_state == ARB_RESP) begin
         if (r_owner) begin
            m1_rvalid = w_in_range;
            m1_err    = ~w_in_range;
            if (w_in_range && !r_we) m1_rdata = mem_rdata;
         end else begin
            m0_rvalid = w_in_range;
            m0_err    = ~w_in_range;
            if (w_in_range && !r_we) m0_rdata = mem_rdata;
         end
      end
   end

   assign cpu_stall = m0_req & ~(m0_rvalid | m0_err);

endmodule
